sha256_hash_engine: RTL and testbench
=====================================

Name: sha256_hash_engine

Overview:
Single-block SHA-256 hashing accelerator. On a go pulse it reads a message of up to 55 bytes from an external byte-wide SRAM. It reads the 64 round constants K and the 8 initial hash words H from two 32-bit SRAMs, pads the message internally, runs the 64-round compression, and writes the 8-word digest to an output SRAM. It sits behind four single-port synchronous SRAMs with a go/finish handshake to the host.

Parameters:
OUTPUT_LENGTH, 8, depth of the output memory in 32-bit words.
MAX_MESSAGE_LENGTH, 55, maximum message bytes (one 512-bit block after padding).
NUMBER_OF_Ks, 64, round constant count.
NUMBER_OF_Hs, 8, initial hash word count.
SYMBOL_WIDTH, 8, message symbol width.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
xxx__dut__go  in  1  start request.
xxx__dut__msg_length  in  clog2(MAX_MESSAGE_LENGTH)+1 (7)  message length in bytes, 0..55.
dut__xxx__finish  out  1  done flag.
dut__msg__address  out  clog2(MAX_MESSAGE_LENGTH) (6)  message byte address.
dut__msg__enable / dut__msg__write  out  1 each  message read enable; write tied 0.
msg__dut__data  in  8  message read data.
dut__kmem__address  out  6  K index; dut__kmem__enable out 1; dut__kmem__write out 1, tied 0.
kmem__dut__data  in  32  K word.
dut__hmem__address  out  3  H index; dut__hmem__enable out 1; dut__hmem__write out 1, tied 0.
hmem__dut__data  in  32  H word.
dut__dom__address  out  clog2(OUTPUT_LENGTH) (3)  output word address.
dut__dom__data  out  32  output write data.
dut__dom__enable / dut__dom__write  out  1 each  output write strobe; both high together.

Behaviour:
- SRAM protocol: address/enable presented in cycle t; read data is valid at the rising edge ending cycle t+1 (one-cycle read latency). Reads must be pipelined one address ahead.
- Reset: state returns to IDLE. finish=0. All enables and writes are 0. Addresses and dom data are 0.
- FSM states: IDLE, LOAD_H, LOAD_MSG, SCHEDULE/ROUNDS, WRITE, DONE.
- IDLE/DONE, go sampled high: latch msg_length, drop finish to 0 the next cycle, enter LOAD_H.
- go is ignored in every other state. Re-pulsing go mid-run has no effect.
- go held continuously high starts a new run immediately after each DONE.
- LOAD_H: read H[0..7] into h0..h7 and a..h.
- LOAD_MSG: read bytes 0..len-1, packed big-endian into W[0..15].
  - Padding: byte len = 0x80; bytes len+1..55 = 0x00; bytes 56..63 = 64-bit big-endian bit length (len*8).
  - len=0: no message reads are issued.
- ROUNDS: 64 rounds, one per cycle.
  - W[t] for t≥16: σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16], using a 16-entry rolling window.
  - K[t] is prefetched one cycle ahead from kmem.
  - T1 = h+Σ1(e)+Ch(e,f,g)+K[t]+W[t]; T2 = Σ0(a)+Maj(a,b,c).
  - All additions are mod 2^32.
- WRITE: dom[i] = H[i]+final working var (mod 2^32), written for i=0..7 in eight consecutive cycles, enable=write=1.
- DONE: finish=1 the cycle after the last write. finish holds 1 until the next go is accepted.
- Total latency from go to finish: at most 120 + len cycles; must fit within 500 clocks.
- Reset mid-operation: aborts immediately. No further memory writes. finish=0.
- msg_length >55: clamped to 55.

Optional Feature:
MSG_SCHEDULE_OUT_EN.
- Defined: OUTPUT_LENGTH must be 16. After the digest, W[0..15] (the padded message block) is written instead, at dom addresses 0..15, and finish follows the last of those writes.
- Undefined: only the 8-word digest is written at addresses 0..7.

Decomposition:
- Package sha256_pkg holds:
  - the state enum;
  - width constants (MSG_ADDR_W=6, K_ADDR_W=6, H_ADDR_W=3);
  - functions Σ0, Σ1, σ0, σ1, Ch, Maj.
- One natural sub-module, sha256_round: combinational round update of (a..h, K, W) to next a..h.
- The sram model (synchronous, 1-cycle read latency, optional init file) is a verification-only collaborator.

Test Plan:
- Message "hello", len=5, go pulse 1 cycle -> dom[0..7] = 2cf24dba 5fb0a30e 26e83b2a c5b9e29e 1b161e5c 1fa7425e 73043362 938b9824; finish rises ≤500 clocks after go.
- len=0 -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; no message reads.
- "abc", len=3 -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Go pulse, then go high for 10 cycles mid-run -> ignored; digest and cycle count identical to a single-pulse run.
- Go held high for 1000 cycles -> back-to-back runs with identical digests; finish low/high per run.
- Reset asserted mid-ROUNDS -> finish=0 and enables=0 immediately; next go yields correct digest; len=55 message matches reference model.

Source files
------------

// File: rtl/sha256_hash_engine_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the single-block SHA-256 engine: memory geometry,
// FSM state codes, the working-variable and message-block types, the SHA-256
// bit-mixing functions, and the initial padded-block builder.
//
// Build option: define MSG_SCHEDULE_OUT_EN to widen the output memory to
// 16 words and append the padded message block after the digest.
// ---------------------------------------------------------------------------
package sha256_pkg;

    localparam int MAX_MESSAGE_LENGTH = 55;
    localparam int NUMBER_OF_Ks       = 64;
    localparam int NUMBER_OF_Hs       = 8;
    localparam int SYMBOL_WIDTH       = 8;
`ifdef MSG_SCHEDULE_OUT_EN
    localparam int OUTPUT_LENGTH      = 16;
    localparam int WRITE_WORDS        = NUMBER_OF_Hs + 16;
`else
    localparam int OUTPUT_LENGTH      = 8;
    localparam int WRITE_WORDS        = NUMBER_OF_Hs;
`endif

    localparam int MSG_ADDR_W = 6;
    localparam int K_ADDR_W   = 6;
    localparam int H_ADDR_W   = 3;
    localparam int LEN_W      = 7;
    localparam int DOM_ADDR_W = $clog2(OUTPUT_LENGTH);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_H   = 3'd1;
    localparam logic [2:0] ST_LOAD_MSG = 3'd2;
    localparam logic [2:0] ST_ROUNDS   = 3'd3;
    localparam logic [2:0] ST_WRITE    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Index 0 is 'a' (or H0), index 7 is 'h' (or H7).
    typedef logic [NUMBER_OF_Hs-1:0][31:0] hash_t;
    // Index 0 is W[0], the first big-endian word of the block.
    typedef logic [15:0][31:0] block_t;

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Block with only padding in place: 0x80 at byte 'len', zeros elsewhere,
    // bit length in the last word. Message bytes are overlaid afterwards.
    // len never exceeds 55, so the upper length word is always zero.
    function automatic block_t pad_block(input logic [LEN_W-1:0] len);
        block_t b;
        b = '0;
        b[len[5:2]][{~len[1:0], 3'b000} +: 8] = 8'h80;
        b[15] = 32'(len) << 3;
        return b;
    endfunction

endpackage

// File: rtl/sha256_hash_engine_round.sv
// ---------------------------------------------------------------------------
// sha256_round
// Combinational SHA-256 compression round: (a..h, K[t], W[t]) -> next a..h.
// Ports:
//   cur  in  hash_t  working variables a..h (index 0 = a)
//   k_in in  32      round constant K[t]
//   w_in in  32      schedule word W[t]
//   nxt  out hash_t  working variables after the round
// ---------------------------------------------------------------------------
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t       cur,
    input  logic [31:0] k_in,
    input  logic [31:0] w_in,
    output hash_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = cur[7] + big_sigma1(cur[4]) + ch(cur[4], cur[5], cur[6]) + k_in + w_in;
        t2 = big_sigma0(cur[0]) + maj(cur[0], cur[1], cur[2]);
        nxt    = {cur[6:0], 32'd0};
        nxt[0] = t1 + t2;
        nxt[4] = cur[3] + t1;
    end

endmodule

// File: rtl/sha256_hash_engine.sv
// ---------------------------------------------------------------------------
// sha256_hash_engine
// Single-block SHA-256 accelerator behind four single-port synchronous SRAMs
// (1-cycle read latency). A go pulse in IDLE/DONE starts: load H, load and
// pad the message, 64 rounds, write the digest, then raise finish.
// Ports:
//   clk, reset (async, active high)
//   xxx__dut__go, xxx__dut__msg_length  start request and byte length
//   dut__xxx__finish                    high in DONE until the next go
//   dut__msg__*/msg__dut__data          message byte SRAM (read only)
//   dut__kmem__*/kmem__dut__data        round constant SRAM (read only)
//   dut__hmem__*/hmem__dut__data        initial hash SRAM (read only)
//   dut__dom__*                         digest output SRAM (write only)
// Build option: MSG_SCHEDULE_OUT_EN also writes the padded block W[0..15]
// at output addresses 0..15 after the digest.
// ---------------------------------------------------------------------------
module sha256_hash_engine
    import sha256_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    xxx__dut__go,
    input  logic [LEN_W-1:0]        xxx__dut__msg_length,
    output logic                    dut__xxx__finish,
    output logic [MSG_ADDR_W-1:0]   dut__msg__address,
    output logic                    dut__msg__enable,
    output logic                    dut__msg__write,
    input  logic [SYMBOL_WIDTH-1:0] msg__dut__data,
    output logic [K_ADDR_W-1:0]     dut__kmem__address,
    output logic                    dut__kmem__enable,
    output logic                    dut__kmem__write,
    input  logic [31:0]             kmem__dut__data,
    output logic [H_ADDR_W-1:0]     dut__hmem__address,
    output logic                    dut__hmem__enable,
    output logic                    dut__hmem__write,
    input  logic [31:0]             hmem__dut__data,
    output logic [DOM_ADDR_W-1:0]   dut__dom__address,
    output logic [31:0]             dut__dom__data,
    output logic                    dut__dom__enable,
    output logic                    dut__dom__write
);

    localparam logic [6:0] ROUND_LAST = 7'(NUMBER_OF_Ks - 1);
    localparam logic [6:0] WRITE_LAST = 7'(WRITE_WORDS - 1);
    localparam logic [6:0] H_LAST     = 7'(NUMBER_OF_Hs);

    logic [2:0]       state_q, state_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    hash_t            h_init_q, h_init_d;
    hash_t            work_q, work_d;
    hash_t            round_nxt;
    block_t           w_q, w_d;
`ifdef MSG_SCHEDULE_OUT_EN
    block_t           blk_q, blk_d;
`endif

    logic [31:0]      w_new;
    logic [2:0]       h_idx;
    logic [5:0]       b_idx;
    logic [LEN_W-1:0] len_clamped;

    sha256_round u_round (
        .cur  (work_q),
        .k_in (kmem__dut__data),
        .w_in (w_q[0]),
        .nxt  (round_nxt)
    );

    // The window always holds W[t..t+15]; this is W[t+16].
    assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    // Read data lags the counter by one cycle.
    assign h_idx = cnt_q[2:0] - 3'd1;
    assign b_idx = cnt_q[5:0] - 6'd1;

    assign len_clamped = (xxx__dut__msg_length > 7'(MAX_MESSAGE_LENGTH))
                       ? 7'(MAX_MESSAGE_LENGTH) : xxx__dut__msg_length;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        h_init_d = h_init_q;
        work_d   = work_q;
        w_d      = w_q;
`ifdef MSG_SCHEDULE_OUT_EN
        blk_d    = blk_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (xxx__dut__go) begin
                    len_d   = len_clamped;
                    w_d     = pad_block(len_clamped);
                    cnt_d   = '0;
                    state_d = ST_LOAD_H;
                end
            end
            ST_LOAD_H: begin
                if (cnt_q != '0) begin
                    h_init_d[h_idx] = hmem__dut__data;
                    work_d[h_idx]   = hmem__dut__data;
                end
                if (cnt_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_MSG;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_LOAD_MSG: begin
                if (cnt_q != '0) begin
                    w_d[b_idx[5:2]][{~b_idx[1:0], 3'b000} +: 8] = msg__dut__data;
                end
                if (cnt_q == len_q) begin
`ifdef MSG_SCHEDULE_OUT_EN
                    blk_d = w_d;
`endif
                    cnt_d   = '0;
                    state_d = ST_ROUNDS;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_ROUNDS: begin
                work_d = round_nxt;
                w_d    = {w_new, w_q[15:1]};
                if (cnt_q == ROUND_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == WRITE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Memory strobes are decoded from state and counter, so an asynchronous
    // reset silences them in the same instant it clears the state.
    always_comb begin
        dut__xxx__finish   = (state_q == ST_DONE);
        dut__msg__address  = '0;
        dut__msg__enable   = 1'b0;
        dut__msg__write    = 1'b0;
        dut__kmem__address = '0;
        dut__kmem__enable  = 1'b0;
        dut__kmem__write   = 1'b0;
        dut__hmem__address = '0;
        dut__hmem__enable  = 1'b0;
        dut__hmem__write   = 1'b0;
        dut__dom__address  = '0;
        dut__dom__data     = '0;
        dut__dom__enable   = 1'b0;
        dut__dom__write    = 1'b0;
        case (state_q)
            ST_LOAD_H: begin
                if (cnt_q < H_LAST) begin
                    dut__hmem__enable  = 1'b1;
                    dut__hmem__address = cnt_q[2:0];
                end
            end
            ST_LOAD_MSG: begin
                if (cnt_q < len_q) begin
                    dut__msg__enable  = 1'b1;
                    dut__msg__address = cnt_q[5:0];
                end else begin
                    // Prefetch K[0] so it is on the bus for the first round.
                    dut__kmem__enable = 1'b1;
                end
            end
            ST_ROUNDS: begin
                if (cnt_q != ROUND_LAST) begin
                    dut__kmem__enable  = 1'b1;
                    dut__kmem__address = cnt_q[5:0] + 6'd1;
                end
            end
            ST_WRITE: begin
                dut__dom__enable = 1'b1;
                dut__dom__write  = 1'b1;
`ifdef MSG_SCHEDULE_OUT_EN
                if (cnt_q < 7'(NUMBER_OF_Hs)) begin
                    dut__dom__address = DOM_ADDR_W'(cnt_q);
                    dut__dom__data    = h_init_q[cnt_q[2:0]] + work_q[cnt_q[2:0]];
                end else begin
                    dut__dom__address = DOM_ADDR_W'(cnt_q - 7'(NUMBER_OF_Hs));
                    dut__dom__data    = blk_q[dut__dom__address];
                end
`else
                dut__dom__address = cnt_q[2:0];
                dut__dom__data    = h_init_q[cnt_q[2:0]] + work_q[cnt_q[2:0]];
`endif
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            // NOTE: the H, working-variable and block registers are reset too;
            // they are flops rather than an SRAM, and a known value after
            // reset keeps an aborted run from leaking into the next one.
            h_init_q <= '0;
            work_q   <= '0;
            w_q      <= '0;
`ifdef MSG_SCHEDULE_OUT_EN
            blk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            h_init_q <= h_init_d;
            work_q   <= work_d;
            w_q      <= w_d;
`ifdef MSG_SCHEDULE_OUT_EN
            blk_q    <= blk_d;
`endif
        end
    end

endmodule

// File: tb/tb_sha256_hash_engine.sv
// ---------------------------------------------------------------------------
// tb_sha256_hash_engine
// Self-checking bench for sha256_hash_engine: SRAM models, a behavioural
// SHA-256 reference, known-answer vectors and randomized messages.
// ---------------------------------------------------------------------------
module tb_sha256_hash_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [6:0]  msg_length = '0;

    logic        finish;
    logic [5:0]  msg_addr;
    logic        msg_en, msg_wr;
    logic [7:0]  msg_rdata = '0;
    logic [5:0]  k_addr;
    logic        k_en, k_wr;
    logic [31:0] k_rdata = '0;
    logic [2:0]  h_addr;
    logic        h_en, h_wr;
    logic [31:0] h_rdata = '0;
    logic [2:0]  dom_addr;
    logic [31:0] dom_data;
    logic        dom_en, dom_wr;

    always #5 clk = ~clk;

    sha256_hash_engine dut (
        .clk                  (clk),
        .reset                (reset),
        .xxx__dut__go         (go),
        .xxx__dut__msg_length (msg_length),
        .dut__xxx__finish     (finish),
        .dut__msg__address    (msg_addr),
        .dut__msg__enable     (msg_en),
        .dut__msg__write      (msg_wr),
        .msg__dut__data       (msg_rdata),
        .dut__kmem__address   (k_addr),
        .dut__kmem__enable    (k_en),
        .dut__kmem__write     (k_wr),
        .kmem__dut__data      (k_rdata),
        .dut__hmem__address   (h_addr),
        .dut__hmem__enable    (h_en),
        .dut__hmem__write     (h_wr),
        .hmem__dut__data      (h_rdata),
        .dut__dom__address    (dom_addr),
        .dut__dom__data       (dom_data),
        .dut__dom__enable     (dom_en),
        .dut__dom__write      (dom_wr)
    );

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    logic [31:0] h_tab [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // SRAM models: address in cycle t, data valid through cycle t+1.
    logic [7:0]  msg_mem [64];
    logic [31:0] dom_mem [8];
    int          msg_reads = 0;
    int          dom_writes = 0;

    always @(posedge clk) begin
        if (msg_en) begin
            msg_rdata <= msg_mem[msg_addr];
            msg_reads <= msg_reads + 1;
        end
        if (k_en) k_rdata <= k_tab[k_addr];
        if (h_en) h_rdata <= h_tab[h_addr];
        if (dom_en && dom_wr) begin
            dom_mem[dom_addr] <= dom_data;
            dom_writes        <= dom_writes + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_hash(input int len);
        logic [7:0]  blk [64];
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [63:0] bits;
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 64; i++) blk[i] = (i < len) ? msg_mem[i] : 8'h00;
        blk[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 8; i++) blk[56 + i] = bits[63 - 8 * i -: 8];
        for (int t = 0; t < 16; t++)
            w[t] = {blk[4 * t], blk[4 * t + 1], blk[4 * t + 2], blk[4 * t + 3]};
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = h_tab[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = h_tab[i] + v[i];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic load_string(input string s);
        for (int i = 0; i < 64; i++) msg_mem[i] = 8'($urandom);
        for (int i = 0; i < s.len(); i++) msg_mem[i] = s[i];
    endtask

    task automatic load_random();
        for (int i = 0; i < 64; i++) msg_mem[i] = 8'($urandom);
    endtask

    task automatic check_digest(input string tag, input logic [255:0] exp);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_dom%0d", tag, i), 64'(dom_mem[i]), 64'(exp[255 - 32 * i -: 32]));
    endtask

    // Pulse go and wait (bounded) for finish; optional mid-run go burst.
    task automatic run_hash(input string tag, input int len_in, input bit mid_go, output int cyc);
        bit done;
        @(negedge clk);
        go = 1'b1;
        msg_length = 7'(len_in);
        @(negedge clk);
        go = 1'b0;
        cyc = 1;
        done = 1'b0;
        check({tag, "_finish_drop"}, 64'(finish), 64'd0);
        while (cyc < 500 && !done) begin
            if (mid_go) go = (cyc >= 20 && cyc < 30);
            @(negedge clk);
            cyc++;
            if (finish) done = 1'b1;
        end
        go = 1'b0;
        check({tag, "_finish_in_time"}, 64'(done), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int cyc, cyc_base, reads0, len, writes0, runs, cur_high, max_high;
        logic [255:0] exp;

        for (int i = 0; i < 8; i++) dom_mem[i] = '0;
        load_random();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_enables", 64'({msg_en, k_en, h_en, dom_en, dom_wr}), 64'd0);
        check("rst_writes", 64'({msg_wr, k_wr, h_wr}), 64'd0);
        check("rst_addrs", 64'({msg_addr, k_addr, h_addr, dom_addr}), 64'd0);
        check("rst_dom_data", 64'(dom_data), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // "hello"
        load_string("hello");
        reads0 = msg_reads;
        run_hash("hello", 5, 1'b0, cyc);
        check_digest("hello", 256'h2cf24dba5fb0a30e26e83b2ac5b9e29e1b161e5c1fa7425e73043362938b9824);
        check("hello_reads", 64'(msg_reads - reads0), 64'd5);
        check("hello_latency", 64'(cyc <= 125), 64'd1);

        // Empty message: no message reads at all
        load_random();
        reads0 = msg_reads;
        run_hash("empty", 0, 1'b0, cyc);
        check_digest("empty", 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
        check("empty_reads", 64'(msg_reads - reads0), 64'd0);

        // "abc" baseline, then again with a go burst mid-run
        load_string("abc");
        run_hash("abc", 3, 1'b0, cyc_base);
        check_digest("abc", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        for (int i = 0; i < 8; i++) dom_mem[i] = '0;
        run_hash("midgo", 3, 1'b1, cyc);
        check_digest("midgo", 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        check("midgo_cycles", 64'(cyc), 64'(cyc_base));

        // Randomized messages against the reference model
        for (int n = 0; n < 5; n++) begin
            load_random();
            len = (n == 0) ? 55 : (n == 1) ? 1 : int'($urandom_range(2, 54));
            exp = ref_hash(len);
            reads0 = msg_reads;
            run_hash($sformatf("rand%0d", n), len, 1'b0, cyc);
            check_digest($sformatf("rand%0d", n), exp);
            check($sformatf("rand%0d_reads", n), 64'(msg_reads - reads0), 64'(len));
            check($sformatf("rand%0d_latency", n), 64'(cyc <= 121 + len), 64'd1);
        end

        // Length above 55 is clamped
        load_random();
        exp = ref_hash(55);
        reads0 = msg_reads;
        run_hash("clamp", 100, 1'b0, cyc);
        check_digest("clamp", exp);
        check("clamp_reads", 64'(msg_reads - reads0), 64'd55);

        // go held high: back-to-back runs, each digest correct, finish one cycle
        load_string("abc");
        exp = ref_hash(3);
        runs = 0;
        cur_high = 0;
        max_high = 0;
        @(negedge clk);
        go = 1'b1;
        msg_length = 7'd3;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (finish) begin
                cur_high++;
                if (cur_high == 1) begin
                    runs++;
                    check_digest($sformatf("held%0d", runs), exp);
                end
            end else begin
                cur_high = 0;
            end
            if (cur_high > max_high) max_high = cur_high;
        end
        go = 1'b0;
        check("held_runs", 64'(runs >= 7), 64'd1);
        check("held_finish_width", 64'(max_high), 64'd1);
        cyc = 0;
        while (!finish && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("held_drain", 64'(finish), 64'd1);

        // Reset in the middle of the rounds
        load_random();
        @(negedge clk);
        go = 1'b1;
        msg_length = 7'd20;
        @(negedge clk);
        go = 1'b0;
        repeat (50) @(negedge clk);
        writes0 = dom_writes;
        reset = 1'b1;
        #1;
        check("abort_finish", 64'(finish), 64'd0);
        check("abort_enables", 64'({msg_en, k_en, h_en, dom_en, dom_wr}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_writes", 64'(dom_writes - writes0), 64'd0);
        check("abort_idle_finish", 64'(finish), 64'd0);

        load_random();
        exp = ref_hash(55);
        run_hash("post_rst", 55, 1'b0, cyc);
        check_digest("post_rst", exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
